// File: rtl/ysyx_24110015_axi_arbiter_if.sv
// AXI-Lite bundle shared by the arbiter's requesters
// and its downstream slave port.
interface axi_lite_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, rready,
    output awaddr, awvalid, wdata, wstrb,
    output wvalid, bready,
    input  arready, rdata, rresp, rvalid,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    input  awaddr, awvalid, wdata, wstrb,
    input  wvalid, bready,
    output arready, rdata, rresp, rvalid,
    output awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/ysyx_24110015_axi_arbiter.sv
// Two-master AXI-Lite arbiter, one transaction in flight.
// YSYX_24110015_ARB_TRACE_EN enables grant/response tracing.
module ysyx_24110015_axi_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input logic       clk,
  input logic       rst,
  axi_lite_if.slave  m0,
  axi_lite_if.slave  m1,
  axi_lite_if.master s
);
  typedef enum logic [2:0] {
    IDLE, RADDR, RDATA, WREQ, WRESP
  } state_e;

  state_e r_state, w_state_nxt;
  logic r_g, r_lg, r_aw_done, r_w_done;
  logic w_g_nxt, w_lg_nxt;
  logic w_aw_done_nxt, w_w_done_nxt;

  logic w_req0, w_req1, w_pick, w_pick_wr;
  logic [31:0] w_mi_araddr, w_mi_awaddr, w_mi_wdata;
  logic [3:0]  w_mi_wstrb;
  logic w_mi_arvalid, w_mi_rready, w_mi_awvalid;
  logic w_mi_wvalid, w_mi_bready;

  logic [31:0] w_s_araddr, w_s_awaddr, w_s_wdata;
  logic [3:0]  w_s_wstrb;
  logic w_s_arvalid, w_s_rready, w_s_awvalid;
  logic w_s_wvalid, w_s_bready;

  logic [31:0] w_mo_rdata;
  logic [1:0]  w_mo_rresp, w_mo_bresp;
  logic w_mo_arready, w_mo_rvalid, w_mo_awready;
  logic w_mo_wready, w_mo_bvalid;

  logic w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_b_hs;

  assign w_req0 = m0.arvalid | m0.awvalid | m0.wvalid;
  assign w_req1 = m1.arvalid | m1.awvalid | m1.wvalid;
  assign w_pick = (w_req0 & w_req1)
                ? (RR_EN ? ~r_lg : 1'b0) : w_req1;
  assign w_pick_wr = w_pick
                   ? (m1.awvalid | m1.wvalid)
                   : (m0.awvalid | m0.wvalid);

  assign w_mi_araddr  = r_g ? m1.araddr  : m0.araddr;
  assign w_mi_arvalid = r_g ? m1.arvalid : m0.arvalid;
  assign w_mi_rready  = r_g ? m1.rready  : m0.rready;
  assign w_mi_awaddr  = r_g ? m1.awaddr  : m0.awaddr;
  assign w_mi_awvalid = r_g ? m1.awvalid : m0.awvalid;
  assign w_mi_wdata   = r_g ? m1.wdata   : m0.wdata;
  assign w_mi_wstrb   = r_g ? m1.wstrb   : m0.wstrb;
  assign w_mi_wvalid  = r_g ? m1.wvalid  : m0.wvalid;
  assign w_mi_bready  = r_g ? m1.bready  : m0.bready;

  assign w_ar_hs = w_s_arvalid & s.arready;
  assign w_r_hs  = s.rvalid & w_s_rready;
  assign w_aw_hs = w_s_awvalid & s.awready;
  assign w_w_hs  = w_s_wvalid & s.wready;
  assign w_b_hs  = s.bvalid & w_s_bready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_g       <= 1'b0;
      r_lg      <= 1'b1;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_g       <= w_g_nxt;
      r_lg      <= w_lg_nxt;
      r_aw_done <= w_aw_done_nxt;
      r_w_done  <= w_w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_g_nxt       = r_g;
    w_lg_nxt      = r_lg;
    w_aw_done_nxt = r_aw_done;
    w_w_done_nxt  = r_w_done;
    unique case (r_state)
      IDLE: if (w_req0 | w_req1) begin
        w_g_nxt       = w_pick;
        w_aw_done_nxt = 1'b0;
        w_w_done_nxt  = 1'b0;
        w_state_nxt   = w_pick_wr ? WREQ : RADDR;
      end
      RADDR: if (w_ar_hs) w_state_nxt = RDATA;
      RDATA: if (w_r_hs) begin
        w_state_nxt = IDLE;
        w_lg_nxt    = r_g;
      end
      WREQ: begin
        w_aw_done_nxt = r_aw_done | w_aw_hs;
        w_w_done_nxt  = r_w_done | w_w_hs;
        if (w_aw_done_nxt & w_w_done_nxt)
          w_state_nxt = WRESP;
      end
      WRESP: if (w_b_hs) begin
        w_state_nxt = IDLE;
        w_lg_nxt    = r_g;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Held in reset, the ports look exactly like IDLE.
  always_comb begin
    w_s_araddr   = '0;
    w_s_arvalid  = 1'b0;
    w_s_rready   = 1'b0;
    w_s_awaddr   = '0;
    w_s_awvalid  = 1'b0;
    w_s_wdata    = '0;
    w_s_wstrb    = '0;
    w_s_wvalid   = 1'b0;
    w_s_bready   = 1'b0;
    w_mo_arready = 1'b0;
    w_mo_rdata   = '0;
    w_mo_rresp   = '0;
    w_mo_rvalid  = 1'b0;
    w_mo_awready = 1'b0;
    w_mo_wready  = 1'b0;
    w_mo_bresp   = '0;
    w_mo_bvalid  = 1'b0;
    if (rst) begin
      unique case (r_state)
        RADDR: begin
          w_s_araddr   = w_mi_araddr;
          w_s_arvalid  = w_mi_arvalid;
          w_mo_arready = s.arready;
        end
        RDATA: begin
          w_mo_rdata  = s.rdata;
          w_mo_rresp  = s.rresp;
          w_mo_rvalid = s.rvalid;
          w_s_rready  = w_mi_rready;
        end
        WREQ: begin
          w_s_awaddr   = w_mi_awaddr;
          w_s_awvalid  = w_mi_awvalid & ~r_aw_done;
          w_mo_awready = s.awready & ~r_aw_done;
          w_s_wdata    = w_mi_wdata;
          w_s_wstrb    = w_mi_wstrb;
          w_s_wvalid   = w_mi_wvalid & ~r_w_done;
          w_mo_wready  = s.wready & ~r_w_done;
        end
        WRESP: begin
          w_mo_bresp  = s.bresp;
          w_mo_bvalid = s.bvalid;
          w_s_bready  = w_mi_bready;
        end
        default: ;
      endcase
    end
  end

  assign s.araddr  = w_s_araddr;
  assign s.arvalid = w_s_arvalid;
  assign s.rready  = w_s_rready;
  assign s.awaddr  = w_s_awaddr;
  assign s.awvalid = w_s_awvalid;
  assign s.wdata   = w_s_wdata;
  assign s.wstrb   = w_s_wstrb;
  assign s.wvalid  = w_s_wvalid;
  assign s.bready  = w_s_bready;

  assign m0.arready = ~r_g & w_mo_arready;
  assign m0.rvalid  = ~r_g & w_mo_rvalid;
  assign m0.rdata   = r_g ? '0 : w_mo_rdata;
  assign m0.rresp   = r_g ? '0 : w_mo_rresp;
  assign m0.awready = ~r_g & w_mo_awready;
  assign m0.wready  = ~r_g & w_mo_wready;
  assign m0.bvalid  = ~r_g & w_mo_bvalid;
  assign m0.bresp   = r_g ? '0 : w_mo_bresp;

  assign m1.arready = r_g & w_mo_arready;
  assign m1.rvalid  = r_g & w_mo_rvalid;
  assign m1.rdata   = r_g ? w_mo_rdata : '0;
  assign m1.rresp   = r_g ? w_mo_rresp : '0;
  assign m1.awready = r_g & w_mo_awready;
  assign m1.wready  = r_g & w_mo_wready;
  assign m1.bvalid  = r_g & w_mo_bvalid;
  assign m1.bresp   = r_g ? w_mo_bresp : '0;

`ifdef YSYX_24110015_ARB_TRACE_EN
  logic [63:0] r_cyc;
  logic [31:0] r_taddr;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cyc   <= '0;
      r_taddr <= '0;
    end else begin
      r_cyc <= r_cyc + 64'd1;
      if (w_ar_hs) r_taddr <= w_s_araddr;
      if (w_aw_hs) r_taddr <= w_s_awaddr;
      if (r_state == IDLE && (w_req0 | w_req1))
        $display("[arb] cyc=%0d grant=m%0d %s",
                 r_cyc, w_pick, w_pick_wr ? "W" : "R");
      if (r_state == RDATA && w_r_hs)
        $display("[arb] cyc=%0d R addr=%h resp=%0d",
                 r_cyc, r_taddr, s.rresp);
      if (r_state == WRESP && w_b_hs)
        $display("[arb] cyc=%0d W addr=%h resp=%0d",
                 r_cyc, r_taddr, s.bresp);
    end
  end
`endif
endmodule

// File: tb/tb_ysyx_24110015_axi_arbiter.sv
// Directed bench for the two-master AXI-Lite arbiter.
// A round-robin and a fixed-priority instance share stimulus.
module tb_ysyx_24110015_axi_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  axi_lite_if m0 ();
  axi_lite_if m1 ();
  axi_lite_if s ();
  axi_lite_if n0 ();
  axi_lite_if n1 ();
  axi_lite_if ns ();

  ysyx_24110015_axi_arbiter #(.RR_EN(1'b1)) u_rr (
    .clk(clk), .rst(rst), .m0(m0), .m1(m1), .s(s)
  );
  ysyx_24110015_axi_arbiter #(.RR_EN(1'b0)) u_fp (
    .clk(clk), .rst(rst), .m0(n0), .m1(n1), .s(ns)
  );

  assign n0.araddr  = m0.araddr;
  assign n0.arvalid = m0.arvalid;
  assign n0.rready  = m0.rready;
  assign n0.awaddr  = m0.awaddr;
  assign n0.awvalid = m0.awvalid;
  assign n0.wdata   = m0.wdata;
  assign n0.wstrb   = m0.wstrb;
  assign n0.wvalid  = m0.wvalid;
  assign n0.bready  = m0.bready;
  assign n1.araddr  = m1.araddr;
  assign n1.arvalid = m1.arvalid;
  assign n1.rready  = m1.rready;
  assign n1.awaddr  = m1.awaddr;
  assign n1.awvalid = m1.awvalid;
  assign n1.wdata   = m1.wdata;
  assign n1.wstrb   = m1.wstrb;
  assign n1.wvalid  = m1.wvalid;
  assign n1.bready  = m1.bready;
  assign ns.arready = s.arready;
  assign ns.rvalid  = s.rvalid;
  assign ns.rdata   = s.rdata;
  assign ns.rresp   = s.rresp;
  assign ns.awready = s.awready;
  assign ns.wready  = s.wready;
  assign ns.bvalid  = s.bvalid;
  assign ns.bresp   = s.bresp;

  localparam logic [63:0] NONE = 64'hdead_beef_dead_beef;
  localparam logic [31:0] A0 = 32'h0000_0100;
  localparam logic [31:0] A1 = 32'h0000_0200;

  int n_chk = 0;
  int n_err = 0;
  int fp_cnt = 0;
  bit fp_on = 1'b0;
  logic [63:0] q_ar[$];
  logic [63:0] q_aw[$];
  logic [63:0] q_w[$];
  logic [63:0] q_r0[$];
  logic [63:0] q_r1[$];
  logic [63:0] q_b0[$];
  logic [63:0] q_b1[$];

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] vr();
    return {s.arvalid, s.rready, s.awvalid,
            s.wvalid, s.bready,
            m0.arready, m0.rvalid, m0.awready,
            m0.wready, m0.bvalid,
            m1.arready, m1.rvalid, m1.awready,
            m1.wready, m1.bvalid};
  endfunction

  // Sample just after the falling edge; pop the scoreboard
  // for every handshake the DUT presents.
  task automatic smp();
    logic [63:0] v;
    #1;
    if (s.arvalid && s.arready) begin
      v = NONE;
      if (q_ar.size() > 0) v = q_ar.pop_front();
      chk("s_araddr", {32'h0, s.araddr}, v);
    end
    if (s.awvalid && s.awready) begin
      v = NONE;
      if (q_aw.size() > 0) v = q_aw.pop_front();
      chk("s_awaddr", {32'h0, s.awaddr}, v);
    end
    if (s.wvalid && s.wready) begin
      v = NONE;
      if (q_w.size() > 0) v = q_w.pop_front();
      chk("s_wdata", {28'h0, s.wstrb, s.wdata}, v);
    end
    if (m0.rvalid && m0.rready) begin
      v = NONE;
      if (q_r0.size() > 0) v = q_r0.pop_front();
      chk("m0_rdata", {30'h0, m0.rresp, m0.rdata}, v);
    end
    if (m1.rvalid && m1.rready) begin
      v = NONE;
      if (q_r1.size() > 0) v = q_r1.pop_front();
      chk("m1_rdata", {30'h0, m1.rresp, m1.rdata}, v);
    end
    if (m0.bvalid && m0.bready) begin
      v = NONE;
      if (q_b0.size() > 0) v = q_b0.pop_front();
      chk("m0_bresp", {62'h0, m0.bresp}, v);
    end
    if (m1.bvalid && m1.bready) begin
      v = NONE;
      if (q_b1.size() > 0) v = q_b1.pop_front();
      chk("m1_bresp", {62'h0, m1.bresp}, v);
    end
    if (fp_on) begin
      chk("fp_m1_starved",
          {62'h0, n1.arready, n1.rvalid}, 64'h0);
      if (ns.arvalid && ns.arready) begin
        fp_cnt++;
        chk("fp_only_m0", {32'h0, ns.araddr}, {32'h0, A0});
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    adv();
    rst = 1'b1;
  endtask

  initial begin
    m0.araddr = '0; m0.arvalid = 0; m0.rready = 0;
    m0.awaddr = '0; m0.awvalid = 0; m0.wdata = '0;
    m0.wstrb = '0; m0.wvalid = 0; m0.bready = 0;
    m1.araddr = '0; m1.arvalid = 0; m1.rready = 0;
    m1.awaddr = '0; m1.awvalid = 0; m1.wdata = '0;
    m1.wstrb = '0; m1.wvalid = 0; m1.bready = 0;
    s.arready = 0; s.rvalid = 0; s.rdata = '0;
    s.rresp = '0; s.awready = 0; s.wready = 0;
    s.bvalid = 0; s.bresp = '0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    smp();
    chk("reset_vr", {49'h0, vr()}, 64'h0);
    chk("reset_data", {m0.rdata, m1.rdata}, 64'h0);
    rst = 1'b1;
    adv();

    // lone m0 read
    m0.araddr = 32'h8000_0000; m0.arvalid = 1;
    m0.rready = 1; s.arready = 1;
    q_ar.push_back(64'h8000_0000);
    smp();
    chk("r28_bubble", {49'h0, vr()}, 64'h0);
    adv();
    smp();
    chk("r28_arready", {63'h0, m0.arready}, 64'h1);
    adv();
    m0.arvalid = 0; s.arready = 0;
    s.rvalid = 1; s.rdata = 32'h1234_5678;
    q_r0.push_back(64'h1234_5678);
    smp();
    chk("r28_m1_quiet",
        {m1.rdata, m1.rresp, m1.bresp, 23'h0, m1.arready,
         m1.rvalid, m1.awready, m1.wready, m1.bvalid},
        64'h0);
    adv();
    s.rvalid = 0;
    smp();
    chk("r28_idle", {49'h0, vr()}, 64'h0);
    adv();

    // m0 read and m1 write raised together
    do_reset();
    m0.araddr = 32'h8000_0004; m0.arvalid = 1; m0.rready = 1;
    m1.awaddr = 32'ha000_03f8; m1.awvalid = 1;
    m1.wdata = 32'h41; m1.wstrb = 4'h1; m1.wvalid = 1;
    m1.bready = 1;
    s.arready = 1; s.awready = 1; s.wready = 1;
    q_ar.push_back(64'h8000_0004);
    q_aw.push_back(64'ha000_03f8);
    q_w.push_back({28'h0, 4'h1, 32'h41});
    smp();
    chk("r29_idle", {49'h0, vr()}, 64'h0);
    adv();
    smp();
    chk("r29_m0_first", {62'h0, s.arvalid, s.awvalid}, 64'h2);
    adv();
    m0.arvalid = 0;
    s.rvalid = 1; s.rdata = 32'h0000_00aa;
    q_r0.push_back(64'haa);
    smp();
    adv();
    s.rvalid = 0;
    smp();
    chk("r29_gap", {49'h0, vr()}, 64'h0);
    adv();
    smp();
    chk("r29_m1_rdy", {62'h0, m1.awready, m1.wready}, 64'h3);
    adv();
    m1.awvalid = 0; m1.wvalid = 0;
    s.bvalid = 1; s.bresp = 2'b00;
    q_b1.push_back(64'h0);
    smp();
    adv();
    s.bvalid = 0;
    smp();
    chk("r29_done", {49'h0, vr()}, 64'h0);
    adv();

    // m1 W three cycles ahead of AW
    m1.wdata = 32'h77; m1.wstrb = 4'hf; m1.wvalid = 1;
    q_w.push_back({28'h0, 4'hf, 32'h77});
    smp();
    adv();
    smp();
    chk("r31_aw_wait", {62'h0, s.awvalid, m1.wready}, 64'h1);
    adv();
    smp();
    chk("r31_w_once", {62'h0, s.wvalid, m1.wready}, 64'h0);
    adv();
    m1.awaddr = 32'ha000_0010; m1.awvalid = 1;
    q_aw.push_back(64'ha000_0010);
    smp();
    chk("r31_aw_go", {62'h0, s.awvalid, s.wvalid}, 64'h2);
    adv();
    m1.awvalid = 0; m1.wvalid = 0;
    s.bvalid = 1; s.bresp = 2'b00;
    q_b1.push_back(64'h0);
    smp();
    chk("r31_m0_no_b", {63'h0, m0.bvalid}, 64'h0);
    adv();
    s.bvalid = 0;
    smp();
    chk("r31_single_b", {49'h0, vr()}, 64'h0);
    adv();

    // slave stalls arready for 10 cycles
    m0.araddr = 32'h8000_0100; m0.arvalid = 1;
    s.arready = 0;
    smp();
    adv();
    for (int i = 0; i < 10; i++) begin
      smp();
      chk("r33_stall", {31'h0, m0.arready, s.araddr, s.arvalid},
          {31'h0, 1'b0, 32'h8000_0100, 1'b1});
      adv();
    end
    s.arready = 1;
    q_ar.push_back(64'h8000_0100);
    smp();
    chk("r33_arready", {63'h0, m0.arready}, 64'h1);
    adv();
    m0.arvalid = 0; s.arready = 0;
    s.rvalid = 1; s.rdata = 32'hbeef_0001;
    q_r0.push_back(64'hbeef_0001);
    smp();
    adv();
    s.rvalid = 0;

    // reset while stuck in RDATA
    m0.araddr = 32'h8000_0200; m0.arvalid = 1;
    m0.rready = 0; s.arready = 1;
    q_ar.push_back(64'h8000_0200);
    smp();
    adv();
    smp();
    adv();
    m0.arvalid = 0; s.arready = 0;
    s.rvalid = 1; s.rdata = 32'h0000_1111;
    smp();
    chk("r32_rdata", {62'h0, m0.rvalid, s.rready}, 64'h2);
    adv();
    rst = 1'b0;
    smp();
    chk("r32_in_rst", {49'h0, vr()}, 64'h0);
    adv();
    rst = 1'b1; m0.rready = 1;
    smp();
    chk("r32_post", {49'h0, vr()}, 64'h0);
    adv();
    s.rvalid = 0;
    m1.araddr = 32'h9000_0000; m1.arvalid = 1;
    m1.rready = 1; s.arready = 1;
    q_ar.push_back(64'h9000_0000);
    smp();
    adv();
    smp();
    adv();
    m1.arvalid = 0; s.arready = 0;
    s.rvalid = 1; s.rdata = 32'habcd_0123;
    q_r1.push_back(64'habcd_0123);
    smp();
    adv();
    s.rvalid = 0;
    smp();
    chk("r32_m1_done", {49'h0, vr()}, 64'h0);
    adv();

    // both masters reading back to back
    do_reset();
    fp_on = 1'b1;
    m0.araddr = A0; m0.arvalid = 1; m0.rready = 1;
    m1.araddr = A1; m1.arvalid = 1; m1.rready = 1;
    s.arready = 1; s.rvalid = 1; s.rdata = 32'h5a5a_0000;
    for (int k = 0; k < 2; k++) begin
      q_ar.push_back({32'h0, A0});
      q_ar.push_back({32'h0, A1});
      q_r0.push_back(64'h5a5a_0000);
      q_r1.push_back(64'h5a5a_0000);
    end
    for (int i = 0; i < 12; i++) begin
      smp();
      adv();
    end
    m0.arvalid = 0; m1.arvalid = 0;
    s.arready = 0; s.rvalid = 0;
    smp();
    adv();
    fp_on = 1'b0;
    chk("fp_grants", fp_cnt, 64'd4);

    chk("sb_drain",
        q_ar.size() + q_aw.size() + q_w.size() + q_r0.size()
        + q_r1.size() + q_b0.size() + q_b1.size(), 64'h0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
